// File: rtl/demux_pkg.sv
// ============================================================================
//  Module : demux_pkg
//  Brief  : Shared constants and slot state type for the 1-to-4 stream demux.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package demux_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  localparam logic SLOT_EMPTY = 1'b0;
  localparam logic SLOT_FULL  = 1'b1;

  typedef enum logic {
    ST_EMPTY = SLOT_EMPTY,
    ST_FULL  = SLOT_FULL
  } slot_state_e;

endpackage

`default_nettype wire

// File: rtl/demux_slot.sv
// ============================================================================
//  Module : demux_slot
//  Brief  : One-entry output register with handshake and saturating drain count.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_slot_ready,
  output logic [CNT_W-1:0] o_cnt
);

  slot_state_e      r_state;
  slot_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             w_drn;

  assign w_drn        = (r_state == ST_FULL) && i_ready;
  // A full slot can still take a word in the same cycle it is drained.
  assign o_slot_ready = (r_state == ST_EMPTY) || i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (i_load)            w_state_nxt = ST_FULL;
      ST_FULL:  if (w_drn && !i_load)  w_state_nxt = ST_EMPTY;
      default:                         w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_drn && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_data  = r_data;
  assign o_valid = (r_state == ST_FULL);
  assign o_cnt   = r_cnt;

endmodule

`default_nettype wire

// File: rtl/demux_1to4_stream.sv
// ============================================================================
//  Module : demux_1to4_stream
//  Brief  : 1-to-4 handshake demultiplexer with one register slot per channel.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module demux_1to4_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N_CH*WIDTH-1:0] out_data,
  output logic [N_CH-1:0]       out_valid,
  input  logic [N_CH-1:0]       out_ready,
  output logic [N_CH*CNT_W-1:0] xfer_cnt
);

  logic [N_CH-1:0] w_slot_ready;
  logic [N_CH-1:0] w_load;
  logic            w_acc;

  // Ready only looks at the selected slot, so a stalled channel never blocks others.
  assign in_ready = w_slot_ready[in_sel];
  assign w_acc    = in_valid && in_ready;

  always_comb begin
    w_load = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_load[k] = w_acc && (in_sel == SEL_W'(k));
    end
  end

  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_slot
      demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
      ) u_slot (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load[g]),
        .i_data       (in_data),
        .i_ready      (out_ready[g]),
        .o_data       (out_data[g*WIDTH +: WIDTH]),
        .o_valid      (out_valid[g]),
        .o_slot_ready (w_slot_ready[g]),
        .o_cnt        (xfer_cnt[g*CNT_W +: CNT_W])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_demux_1to4_stream.sv
// ============================================================================
//  Module : tb_demux_1to4_stream
//  Brief  : Directed self-checking bench for demux_1to4_stream.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_demux_1to4_stream;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] xfer_cnt;

  logic        in_ready2;
  logic [31:0] out_data2;
  logic [3:0]  out_valid2;
  logic [7:0]  xfer_cnt2;

  int n_checks;
  int n_errors;

  demux_1to4_stream #(.WIDTH(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  // Narrow-counter copy driven in lockstep, used for the saturation case.
  demux_1to4_stream #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .out_data  (out_data2),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 4'h0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    in_data   = 8'h00;
    in_sel    = 2'd0;
    in_valid  = 1'b0;
    out_ready = 4'h0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_valid", out_valid, 4'h0);
    check("rst_data",  out_data,  32'h0);
    check("rst_cnt",   xfer_cnt,  32'h0);
    check("rst_ready", in_ready,  1'b1);

    // 1: single word into a stalled channel 2
    in_data = 8'hA5; in_sel = 2'd2; in_valid = 1'b1;
    tick();
    check("t1_valid", out_valid, 4'b0100);
    check("t1_data2", out_data[23:16], 8'hA5);
    in_data = 8'h5A;
    #1;
    check("t1_stall_ready", in_ready, 1'b0);
    tick();
    in_valid = 1'b0;
    check("t1_hold_data", out_data[23:16], 8'hA5);
    check("t1_hold_valid", out_valid, 4'b0100);

    // 2: streaming with all consumers ready
    do_reset();
    out_ready = 4'hF;
    for (int i = 0; i < 16; i++) begin
      in_data  = 8'(i);
      in_sel   = 2'(i % 4);
      in_valid = 1'b1;
      #1;
      check("t2_ready", in_ready, 1'b1);
      tick();
      check("t2_valid", out_valid[i % 4], 1'b1);
      check("t2_data", out_data[(i % 4)*8 +: 8], 8'(i));
    end
    in_valid = 1'b0;
    tick();
    check("t2_cnt", xfer_cnt, 32'h04040404);
    check("t2_empty", out_valid, 4'h0);

    // 3: channel 1 stalled, channel 3 still accepts
    do_reset();
    in_data = 8'h11; in_sel = 2'd1; in_valid = 1'b1;
    tick();
    in_data = 8'h33; in_sel = 2'd3;
    #1;
    check("t3_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check("t3_valid", out_valid, 4'b1010);
    check("t3_data1", out_data[15:8],  8'h11);
    check("t3_data3", out_data[31:24], 8'h33);

    // 4: simultaneous drain and load on channel 0
    in_data = 8'hC3; in_sel = 2'd0; in_valid = 1'b1;
    tick();
    check("t4_pre_data", out_data[7:0], 8'hC3);
    check("t4_pre_cnt",  xfer_cnt[7:0], 8'd0);
    in_data = 8'h3C; out_ready = 4'b0001;
    #1;
    check("t4_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0; out_ready = 4'h0;
    check("t4_valid", out_valid, 4'b1011);
    check("t4_data0", out_data[7:0], 8'h3C);
    check("t4_cnt0",  xfer_cnt[7:0], 8'd1);

    // 5: five drains on channel 0; narrow counter saturates
    do_reset();
    out_ready = 4'hF;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(8'h80 + i); in_sel = 2'd0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("t5_cnt_w8", xfer_cnt[7:0], 8'd5);
    check("t5_cnt_w2", xfer_cnt2[1:0], 2'd3);
    check("t5_cnt_w2_others", xfer_cnt2[7:2], 6'd0);

    // 6: reset with all slots full and a word on offer
    do_reset();
    for (int k = 0; k < 4; k++) begin
      in_data = 8'(8'h40 + k); in_sel = 2'(k); in_valid = 1'b1;
      tick();
    end
    check("t6_full", out_valid, 4'hF);
    check("t6_data", out_data, 32'h43424140);
    rst = 1'b1; in_data = 8'hEE; in_sel = 2'd2; in_valid = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("t6_rst_valid", out_valid, 4'h0);
    check("t6_rst_cnt",   xfer_cnt,  32'h0);
    check("t6_rst_data",  out_data,  32'h0);
    #1;
    check("t6_ready", in_ready, 1'b1);
    tick();
    check("t6_post_valid", out_valid, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
